// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM address sequencer: FSM encoding,
// default timing and a counter width helper.
package dram_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_CAS  = 3'd3;
  localparam logic [2:0] ST_PRE  = 3'd4;
  localparam logic [2:0] ST_REF  = 3'd5;

  localparam int DEF_NCH   = 2;
  localparam int DEF_MUX_W = 7;
  localparam int DEF_T_RCD = 2;
  localparam int DEF_T_CAS = 2;
  localparam int DEF_T_RP  = 2;
  localparam int DEF_T_REF = 64;

  // Width for a counter that must hold 0..maxv, never narrower than one bit.
  function automatic int cnt_w(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/dram_addr_sequencer_if.sv
// Requester and DRAM-pin bundle of the address sequencer.
interface dram_addr_sequencer_if
  import dram_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int MUX_W = DEF_MUX_W
) ();
  localparam int ADDR_W = 2 * MUX_W;

  logic [NCH-1:0]        req;
  logic [NCH*ADDR_W-1:0] addr;
  logic [NCH-1:0]        gnt;
  logic [NCH-1:0]        done;
  logic [MUX_W-1:0]      ma;
  logic                  mux_s;
  logic                  nras;
  logic                  ncas;
  logic                  busy;

  modport master (output req, addr, input gnt, done, ma, mux_s, nras, ncas, busy);
  modport slave  (input req, addr, output gnt, done, ma, mux_s, nras, ncas, busy);
endinterface

// File: rtl/dram_req_arb.sv
// Combinational fixed-priority arbiter: lowest set request bit wins.
module dram_req_arb
  import dram_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] win,
  output logic           vld
);
  // Two's-complement trick isolates the lowest set bit.
  assign win = req & (~req + NCH'(1));
  assign vld = |req;
endmodule

// File: rtl/dram_addr_sequencer.sv
// Arbitrated DRAM access sequencer: row/column address muxing, RAS/CAS
// strobe timing and periodic RAS-only refresh.
module dram_addr_sequencer
  import dram_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int MUX_W = DEF_MUX_W,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_CAS = DEF_T_CAS,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_REF = DEF_T_REF
) (
  input  logic                 clk,
  input  logic                 nres,
  dram_addr_sequencer_if.slave bus
);
  localparam int ADDR_W = 2 * MUX_W;
  localparam int PH_MAX = ((T_RP > T_RCD + T_CAS) ? T_RP : T_RCD + T_CAS) - 1;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam int REF_W  = cnt_w((T_REF > 0) ? T_REF - 1 : 0);

  localparam logic [PH_W-1:0] RCD_LAST = PH_W'(T_RCD - 1);
  localparam logic [PH_W-1:0] CAS_LAST = PH_W'(T_CAS - 1);
  localparam logic [PH_W-1:0] RP_LAST  = PH_W'(T_RP - 1);
  localparam logic [PH_W-1:0] RF_LAST  = PH_W'(T_RCD + T_CAS - 1);

  logic [2:0]        state, state_nxt;
  logic [PH_W-1:0]   ph_cnt, ph_nxt;
  logic              ref_pend, ref_exp;
  logic [MUX_W-1:0]  ref_row;
  logic [NCH-1:0]    arb_win, own_q;
  logic              arb_vld;
  logic [ADDR_W-1:0] win_addr;
  logic [MUX_W-1:0]  col_q;
  logic              start_acc, enter_ref, ph_last;

  dram_req_arb #(.NCH(NCH)) u_arb (
    .req (bus.req),
    .win (arb_win),
    .vld (arb_vld)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NCH; i++)
      if (arb_win[i]) win_addr = win_addr | bus.addr[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    ph_last = 1'b1;
    case (state)
      ST_ROW:  ph_last = (ph_cnt == RCD_LAST);
      ST_CAS:  ph_last = (ph_cnt == CAS_LAST);
      ST_PRE:  ph_last = (ph_cnt == RP_LAST);
      ST_REF:  ph_last = (ph_cnt == RF_LAST);
      default: ph_last = 1'b1;
    endcase
  end

  // Refresh takes precedence over a waiting request at the IDLE decision.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ref_pend) state_nxt = ST_REF;
               else if (arb_vld) state_nxt = ST_ROW;
      ST_ROW:  if (ph_last) state_nxt = ST_COL;
      ST_COL:  state_nxt = ST_CAS;
      ST_CAS:  if (ph_last) state_nxt = ST_PRE;
      ST_PRE:  if (ph_last) state_nxt = ST_IDLE;
      ST_REF:  if (ph_last) state_nxt = ST_PRE;
      default: state_nxt = ST_IDLE;
    endcase
    ph_nxt = (state_nxt != state || state == ST_IDLE) ? '0 : ph_cnt + 1'b1;
  end

  assign start_acc = (state == ST_IDLE) && (state_nxt == ST_ROW);
  assign enter_ref = (state == ST_IDLE) && (state_nxt == ST_REF);

  generate
    if (T_REF > 0) begin : g_ref
      localparam logic [REF_W-1:0] REF_LAST = REF_W'(T_REF - 1);
      logic [REF_W-1:0] ref_cnt;
      always_ff @(posedge clk) begin
        if (!nres)                  ref_cnt <= '0;
        else if (ref_cnt == REF_LAST) ref_cnt <= '0;
        else                        ref_cnt <= ref_cnt + 1'b1;
      end
      assign ref_exp = (ref_cnt == REF_LAST);
    end else begin : g_noref
      assign ref_exp = 1'b0;
    end
  endgenerate

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!nres) begin
      state     <= ST_IDLE;
      ph_cnt    <= '0;
      ref_pend  <= 1'b0;
      ref_row   <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.ma    <= '0;
      bus.mux_s <= 1'b0;
      bus.nras  <= 1'b1;
      bus.ncas  <= 1'b1;
      bus.busy  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ph_cnt <= ph_nxt;
      if (enter_ref) begin
        ref_pend <= 1'b0;
        ref_row  <= ref_row + 1'b1;
      end else if (ref_exp) begin
        ref_pend <= 1'b1;
      end
      bus.gnt   <= start_acc ? arb_win : '0;
      bus.done  <= (state == ST_CAS && state_nxt == ST_PRE) ? own_q : '0;
      bus.nras  <= !(state_nxt inside {ST_ROW, ST_COL, ST_CAS, ST_REF});
      bus.ncas  <= (state_nxt != ST_CAS);
      bus.mux_s <= (state_nxt == ST_COL) || (state_nxt == ST_CAS);
      bus.busy  <= (state_nxt != ST_IDLE);
      if (start_acc)                                bus.ma <= win_addr[MUX_W-1:0];
      else if (state == ST_ROW && state_nxt == ST_COL) bus.ma <= col_q;
      else if (enter_ref)                           bus.ma <= ref_row;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      col_q <= win_addr[ADDR_W-1:MUX_W];
      own_q <= arb_win;
    end
  end

endmodule

// File: tb/tb_dram_addr_sequencer.sv
// Directed bench for dram_addr_sequencer: one instance without refresh,
// one with a 16-cycle refresh interval.
module tb_dram_addr_sequencer;
  logic clk = 1'b0;
  logic nres0, nres1;
  always #5 clk = ~clk;

  dram_addr_sequencer_if #(.NCH(2), .MUX_W(7)) bus0 ();
  dram_addr_sequencer_if #(.NCH(2), .MUX_W(7)) bus1 ();

  dram_addr_sequencer #(.NCH(2), .MUX_W(7), .T_RCD(2), .T_CAS(2), .T_RP(2), .T_REF(0))
    dut0 (.clk(clk), .nres(nres0), .bus(bus0));
  dram_addr_sequencer #(.NCH(2), .MUX_W(7), .T_RCD(2), .T_CAS(2), .T_RP(2), .T_REF(16))
    dut1 (.clk(clk), .nres(nres1), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, " gnt"},   32'(bus0.gnt),   32'd0);
    chk({tag, " done"},  32'(bus0.done),  32'd0);
    chk({tag, " ma"},    32'(bus0.ma),    32'd0);
    chk({tag, " mux_s"}, 32'(bus0.mux_s), 32'd0);
    chk({tag, " nras"},  32'(bus0.nras),  32'd1);
    chk({tag, " ncas"},  32'(bus0.ncas),  32'd1);
    chk({tag, " busy"},  32'(bus0.busy),  32'd0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [6:0] ma;
    logic       mux_s;
    logic       nras;
    logic       ncas;
    logic       busy;
  } vec_t;

  vec_t tv[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tg, k, last, cyc;
    bit dbl, bad, found;
    logic prev;

    // Single access on ch1, 14'h1A5C -> row 5C, col 34; period 8.
    tv[0] = '{2'b10, 2'b10, 2'b00, 7'h5C, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[1] = '{2'b00, 2'b00, 2'b00, 7'h5C, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[2] = '{2'b00, 2'b00, 2'b00, 7'h34, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[3] = '{2'b00, 2'b00, 2'b00, 7'h34, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[4] = '{2'b00, 2'b00, 2'b00, 7'h34, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5] = '{2'b00, 2'b00, 2'b10, 7'h34, 1'bx, 1'b1, 1'b1, 1'b1};
    tv[6] = '{2'b00, 2'b00, 2'b00, 7'h34, 1'bx, 1'b1, 1'b1, 1'b1};
    tv[7] = '{2'b00, 2'b00, 2'b00, 7'h34, 1'bx, 1'b1, 1'b1, 1'b0};
    tv[8] = '{2'b10, 2'b10, 2'b00, 7'h5C, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[9] = '{2'b00, 2'b00, 2'b00, 7'h5C, 1'b0, 1'b0, 1'b1, 1'b1};

    nres0 = 1'b0; nres1 = 1'b0;
    bus0.req = '0; bus0.addr = '0;
    bus1.req = '0; bus1.addr = '0;
    tick(); tick();
    chk_idle0("rst0");
    chk("rst1 nras", 32'(bus1.nras), 32'd1);
    chk("rst1 busy", 32'(bus1.busy), 32'd0);
    nres0 = 1'b1; nres1 = 1'b1;
    tick();

    bus0.addr = {14'h1A5C, 14'h0000};
    for (int i = 0; i < 10; i++) begin
      bus0.req = tv[i].req;
      tick();
      chk($sformatf("vec%0d gnt", i),  32'(bus0.gnt),  32'(tv[i].gnt));
      chk($sformatf("vec%0d done", i), 32'(bus0.done), 32'(tv[i].done));
      chk($sformatf("vec%0d ma", i),   32'(bus0.ma),   32'(tv[i].ma));
      chk($sformatf("vec%0d nras", i), 32'(bus0.nras), 32'(tv[i].nras));
      chk($sformatf("vec%0d ncas", i), 32'(bus0.ncas), 32'(tv[i].ncas));
      chk($sformatf("vec%0d busy", i), 32'(bus0.busy), 32'(tv[i].busy));
      if (tv[i].mux_s !== 1'bx)
        chk($sformatf("vec%0d mux_s", i), 32'(bus0.mux_s), 32'(tv[i].mux_s));
    end
    bus0.req = '0;
    for (int i = 0; i < 8; i++) tick();

    // Both channels requesting: ch0 first, ch1 one period later.
    bus0.addr = {14'h3FFF, 14'h0081};
    bus0.req  = 2'b11;
    t0 = -1; t1 = -1; dbl = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if ($countones(bus0.gnt) > 1) dbl = 1'b1;
      if (bus0.gnt[0] && t0 < 0) begin
        t0 = c; chk("prio ch0 row", 32'(bus0.ma), 32'h01); bus0.req[0] = 1'b0;
      end
      if (bus0.gnt[1] && t1 < 0) begin
        t1 = c; chk("prio ch1 row", 32'(bus0.ma), 32'h7F); bus0.req[1] = 1'b0;
      end
    end
    chk("prio ch0 first", 32'(t0), 32'd0);
    chk("prio ch1 gap", 32'(t1 - t0), 32'd8);
    chk("prio single gnt", 32'(dbl), 32'd0);

    // Reset held two edges in the middle of an access.
    bus0.addr = {14'h0000, 14'h2A55};
    bus0.req  = 2'b01;
    tick(); tick(); tick();
    nres0 = 1'b0;
    tick(); tick();
    chk_idle0("midrst");
    bus0.req = '0;
    nres0 = 1'b1;
    tick(); tick();

    // Reset during the second CAS cycle aborts without DONE.
    bus0.req = 2'b01;
    tick();
    chk("abort gnt", 32'(bus0.gnt), 32'h1);
    chk("abort row", 32'(bus0.ma), 32'h55);
    bus0.req = '0;
    tick(); tick();
    chk("abort col", 32'(bus0.ma), 32'h54);
    tick(); tick();
    chk("abort cas2 ncas", 32'(bus0.ncas), 32'd0);
    nres0 = 1'b0;
    tick();
    chk("abort nras", 32'(bus0.nras), 32'd1);
    chk("abort ncas", 32'(bus0.ncas), 32'd1);
    chk("abort busy", 32'(bus0.busy), 32'd0);
    chk("abort done", 32'(bus0.done), 32'd0);
    nres0 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.done != 2'b00) bad = 1'b1;
    end
    chk("abort no done", 32'(bad), 32'd0);

    // Refresh every 16 cycles, row counting up and wrapping.
    nres1 = 1'b0;
    tick();
    nres1 = 1'b1;
    prev = bus1.nras;
    k = 0; last = 0; bad = 1'b0;
    for (int c = 0; c < 2300 && k < 130; c++) begin
      tick();
      if (prev == 1'b1 && bus1.nras == 1'b0) begin
        chk($sformatf("ref%0d row", k), 32'(bus1.ma), 32'(k % 128));
        if (k > 0) chk($sformatf("ref%0d interval", k), 32'(c - last), 32'd16);
        last = c;
        k++;
      end
      if (bus1.ncas !== 1'b1) bad = 1'b1;
      prev = bus1.nras;
    end
    chk("ref count", 32'(k), 32'd130);
    chk("ref ncas high", 32'(bad), 32'd0);

    // Refresh and request meet at the same IDLE edge: refresh wins.
    prev = bus1.nras;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (prev == 1'b1 && bus1.nras == 1'b0) found = 1'b1;
      prev = bus1.nras;
    end
    chk("tie sync", 32'(found), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    bus1.addr = {14'h0000, 14'h0123};
    bus1.req  = 2'b01;
    tick();
    chk("tie ref nras", 32'(bus1.nras), 32'd0);
    chk("tie ref ncas", 32'(bus1.ncas), 32'd1);
    chk("tie ref gnt", 32'(bus1.gnt), 32'd0);
    tg = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus1.gnt[0] && tg < 0) begin
        tg = c;
        chk("tie row", 32'(bus1.ma), 32'h23);
        bus1.req = '0;
      end
    end
    chk("tie gnt delay", 32'(tg), 32'd7);

    cyc = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
